// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
// The pipeline side is the master; the arithmetic unit is the slave.
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            Start_i;
    logic [2:0]      Funct3_i;
    logic [XLEN-1:0] InA_i;
    logic [XLEN-1:0] InB_i;
    logic            Flush_i;
    logic            Busy_o;
    logic            Done_o;
    logic [XLEN-1:0] Result_o;

    modport master (
        output Start_i, Funct3_i, InA_i, InB_i, Flush_i,
        input  Busy_o, Done_o, Result_o
    );

    modport slave (
        input  Start_i, Funct3_i, InA_i, InB_i, Flush_i,
        output Busy_o, Done_o, Result_o
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, shift-add multiply and
// restoring divide on operand magnitudes, with sign correction on the way out.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic          Clk_i,
    input  logic          Rst_i,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;

    // Entry decode: magnitudes, sign flags and the no-iteration special cases.
    always_comb begin
        a_signed = (bus.Funct3_i == F_MULH) || (bus.Funct3_i == F_MULHSU) ||
                   (bus.Funct3_i == F_DIV)  || (bus.Funct3_i == F_REM);
        b_signed = (bus.Funct3_i == F_MULH) || (bus.Funct3_i == F_DIV) ||
                   (bus.Funct3_i == F_REM);
        neg_a    = a_signed && bus.InA_i[XLEN-1];
        neg_b    = b_signed && bus.InB_i[XLEN-1];
        mag_a    = neg_a ? -bus.InA_i : bus.InA_i;
        mag_b    = neg_b ? -bus.InB_i : bus.InB_i;
        div_zero = bus.Funct3_i[2] && (bus.InB_i == '0);
        div_ovf  = ((bus.Funct3_i == F_DIV) || (bus.Funct3_i == F_REM)) &&
                   (bus.InA_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.InB_i == '1);
        if (div_zero) special_res = bus.Funct3_i[1] ? bus.InA_i : '1;
        else          special_res = bus.Funct3_i[1] ? '0 : bus.InA_i;
    end

    logic [XLEN:0]     mul_sum, rem_sh, div_diff;
    logic [2*XLEN-1:0] calc_next, prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    // One iteration step; acc holds product hi:lo for multiply, remainder:quotient for divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = rem_sh - {1'b0, opb_q};
        if (!op_q[2])          calc_next = {mul_sum, acc_q[XLEN-1:1]};
        else if (div_diff[XLEN]) calc_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else                   calc_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

        prod = neg_res_q ? -calc_next : calc_next;
        quo  = neg_res_q ? -calc_next[XLEN-1:0] : calc_next[XLEN-1:0];
        rem  = neg_rem_q ? -calc_next[2*XLEN-1:XLEN] : calc_next[2*XLEN-1:XLEN];
        if (op_q == F_MUL)  final_res = prod[XLEN-1:0];
        else if (!op_q[2])  final_res = prod[2*XLEN-1:XLEN];
        else if (!op_q[1])  final_res = quo;
        else                final_res = rem;
    end

    // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                if (bus.Start_i && !bus.Flush_i) begin
                    op_d      = bus.Funct3_i;
                    cnt_d     = '0;
                    opb_d     = mag_b;
                    acc_d     = {{XLEN{1'b0}}, mag_a};
                    neg_res_d = neg_a ^ neg_b;
                    neg_rem_d = neg_a;
                    if (div_zero || div_ovf) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = special_res;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = calc_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = final_res;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A kill abandons the operation without touching the visible result.
        if (bus.Flush_i && (state_q != IDLE)) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign bus.Busy_o   = (state_q != IDLE);
    assign bus.Done_o   = done_q;
    assign bus.Result_o = result_q;
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits in the execute stage alongside the combinational ALU.
- The pipeline holds the instruction in EX while Busy_o is high, then takes Result_o when Done_o is high.
- Arithmetic is one bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
- Operand signs are handled by magnitude conversion on entry and sign correction on exit.

Parameters:
XLEN, 32, operand and result width in bits; must be ≥ 4. The counter width is clog2(XLEN)+1.

Ports:
Clk_i  in  1  clock; all state changes on the rising edge
Rst_i  in  1  synchronous, active-high reset
Start_i  in  1  request; accepted only in a cycle where Busy_o is 0
Funct3_i  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
InA_i  in  XLEN  rs1 operand; sampled at acceptance only
InB_i  in  XLEN  rs2 operand; sampled at acceptance only
Flush_i  in  1  pipeline kill; abandons any in-flight operation
Busy_o  out  1  high whenever state ≠ IDLE
Done_o  out  1  single-cycle pulse; Result_o is valid in this cycle
Result_o  out  XLEN  registered result; holds its value until the next Done_o

Behaviour:
- Reset (Rst_i=1 at an edge):
  - state ← IDLE; Busy_o=0, Done_o=0, Result_o=0, counter=0.
  - Reset overrides Start_i and Flush_i.
  - Reset mid-operation discards the operation and produces no Done_o.
- States: IDLE, CALC, DONE.
- IDLE:
  - Start_i=1 & Flush_i=0 → latch op, |A|/|B| (or raw values for unsigned operands), sign flags and the special-case decode.
  - Next state is CALC, or DONE directly for a special case.
- CALC:
  - Counter runs XLEN iterations, then the state moves to DONE.
  - MUL*: 2·XLEN product register; each cycle add the multiplicand if the multiplier LSB is 1, then shift right.
  - DIV*/REM*: each cycle shift remainder:quotient left 1, trial-subtract the divisor, keep the result if non-negative and set the quotient LSB.
- DONE:
  - Result_o ← sign-corrected selection; Done_o=1 for exactly this cycle; next state is IDLE.
  - Start_i during DONE is ignored, because Busy_o is still 1.
- Latency:
  - Start accepted at cycle 0 (regular op) → Busy_o=1 for cycles 1..XLEN+1, Done_o=1 in cycle XLEN+1.
  - Earliest next acceptance is cycle XLEN+2.
  - Special cases: Busy_o=1 and Done_o=1 in cycle 1.
- Result selection and signs:
  - MUL = product[XLEN-1:0].
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU: both operands unsigned.
  - All MULH variants return product[2XLEN-1:XLEN] after negating the full 2XLEN product when the result sign is negative.
  - The quotient is negated if sign(A)≠sign(B) (signed ops only).
  - The remainder takes the sign of A (signed ops only).
- Special cases (RISC-V semantics, no trap):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → A.
  - Signed overflow (A = most-negative, B = −1): DIV → A; REM → 0.
- Flush_i=1 in any state other than IDLE → next state IDLE.
  - No Done_o is produced; Result_o keeps its previous value.
  - Flush_i together with Start_i in IDLE → request rejected.
- Start_i while Busy_o=1 is ignored; no queueing.
- All arithmetic is modulo its stated width; no other exceptions or flags.

Test Plan:
1. MUL, A=7, B=−3 (0xFFFFFFFD) → Done_o exactly at cycle 33, Result_o=0xFFFFFFEB, Busy_o high for cycles 1..33.
2. MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF.
3. DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
4. Special cases, each with Done_o at cycle 1:
   - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
   - DIV 0x80000000/−1 → 0x80000000; REM of the same operands → 0.
5. Control interactions:
   - Start, then Flush_i at cycle 10 → no Done_o, Busy_o=0 at cycle 11, Result_o unchanged.
   - A new Start_i at cycle 11 completes normally.
   - Start_i pulsed at cycle 5 mid-op is ignored.
6. Rst_i at cycle 20 of a DIVU → all outputs 0 next cycle.
   - Back-to-back ops with Start_i held high → accepts at 0 and 34, two Done_o pulses.
   - Repeat test 3 with XLEN=8.
